// File: rtl/warn_blink_ctrl.sv
// warn_blink_ctrl: persistence + hysteresis qualifier that turns sensor samples into a level blink request.
// Latency: blink is registered and updates on the same edge that samples the qualifying sample (0 extra cycles).
// Backpressure: none; every sample_valid strobe is consumed in the cycle it is presented.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   sample_valid/sample  one-cycle strobe + unsigned sensor value
//   thresh_hi/thresh_lo  entry (sample >= hi) and exit (sample < lo) thresholds
//   ack                  operator acknowledge, present only with WARN_LATCH_EN
//   blink                registered blink request
// Optional feature: define WARN_LATCH_EN to latch the warning after hold expiry until ack.
module warn_blink_ctrl #(
    parameter int C_W         = 8,
    parameter int C_ARM       = 3,
    parameter int C_ARM_BITS  = 2,
    parameter int C_HOLD      = 25000000,
    parameter int C_HOLD_BITS = 25
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           sample_valid,
    input  logic [C_W-1:0] sample,
    input  logic [C_W-1:0] thresh_hi,
    input  logic [C_W-1:0] thresh_lo,
`ifdef WARN_LATCH_EN
    input  logic           ack,
`endif
    output logic           blink
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_WARN  = 3'd2,
        S_HOLD  = 3'd3,
        S_LATCH = 3'd4
    } state_t;

    localparam logic [C_ARM_BITS-1:0]  ARM_TARGET = C_ARM_BITS'(C_ARM);
    localparam logic [C_HOLD_BITS-1:0] HOLD_INIT  = C_HOLD_BITS'(C_HOLD - 1);

    state_t                 state, state_nxt;
    logic [C_ARM_BITS-1:0]  arm_cnt, arm_nxt, arm_inc;
    logic [C_HOLD_BITS-1:0] hold_cnt, hold_nxt;
    logic                   blink_nxt;
    logic                   over, clear;
    logic                   v_over, v_clear, v_not_clear;

    // Thresholds are compared combinationally against the sample of the same cycle.
    assign over        = (sample >= thresh_hi);
    assign clear       = (sample <  thresh_lo);
    assign v_over      = sample_valid & over;
    assign v_clear     = sample_valid & clear;
    assign v_not_clear = sample_valid & ~clear;
    assign arm_inc     = arm_cnt + C_ARM_BITS'(1);

    always_comb begin
        state_nxt = state;
        arm_nxt   = arm_cnt;
        hold_nxt  = hold_cnt;

        case (state)
            S_IDLE: begin
                if (v_over) begin
                    if (C_ARM == 1) begin
                        state_nxt = S_WARN;
                    end else begin
                        arm_nxt   = C_ARM_BITS'(1);
                        state_nxt = S_ARM;
                    end
                end
            end

            S_ARM: begin
                // Only valid samples advance or break the streak; idle cycles leave it alone.
                if (sample_valid) begin
                    if (over) begin
                        if (arm_inc == ARM_TARGET) begin
                            arm_nxt   = '0;
                            state_nxt = S_WARN;
                        end else begin
                            arm_nxt = arm_inc;
                        end
                    end else begin
                        arm_nxt   = '0;
                        state_nxt = S_IDLE;
                    end
                end
            end

            S_WARN: begin
                if (v_clear) begin
                    hold_nxt  = HOLD_INIT;
                    state_nxt = S_HOLD;
                end
            end

            S_HOLD: begin
                // A non-clear sample abandons the hold, even on the expiry cycle.
                if (v_not_clear) begin
                    state_nxt = S_WARN;
                end else if (hold_cnt == '0) begin
`ifdef WARN_LATCH_EN
                    state_nxt = S_LATCH;
`else
                    state_nxt = S_IDLE;
`endif
                end else begin
                    hold_nxt = hold_cnt - C_HOLD_BITS'(1);
                end
            end

`ifdef WARN_LATCH_EN
            S_LATCH: begin
                // A fresh over sample re-warns immediately and beats a same-cycle ack.
                if (v_over) begin
                    state_nxt = S_WARN;
                end else if (ack) begin
                    state_nxt = S_IDLE;
                end
            end
`endif

            default: begin
                arm_nxt   = '0;
                hold_nxt  = '0;
                state_nxt = S_IDLE;
            end
        endcase

`ifdef WARN_LATCH_EN
        blink_nxt = (state_nxt == S_WARN) || (state_nxt == S_HOLD) || (state_nxt == S_LATCH);
`else
        blink_nxt = (state_nxt == S_WARN) || (state_nxt == S_HOLD);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            arm_cnt  <= '0;
            hold_cnt <= '0;
            blink    <= 1'b0;
        end else begin
            state    <= state_nxt;
            arm_cnt  <= arm_nxt;
            hold_cnt <= hold_nxt;
            blink    <= blink_nxt;
        end
    end

endmodule

// File: tb/tb_warn_blink_ctrl.sv
// tb_warn_blink_ctrl: directed scenarios plus randomized traffic against a behavioural model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: not applicable; stimulus is applied every cycle.
module tb_warn_blink_ctrl;

    localparam int C_W    = 8;
    localparam int C_ARM  = 3;
    localparam int C_HOLD = 4;

    logic           clk;
    logic           reset;
    logic           sample_valid;
    logic [C_W-1:0] sample;
    logic [C_W-1:0] thresh_hi;
    logic [C_W-1:0] thresh_lo;
    logic           ack;
    logic           blink;

    int tests_run = 0;
    int fails     = 0;

    warn_blink_ctrl #(
        .C_W(C_W), .C_ARM(C_ARM), .C_ARM_BITS(2), .C_HOLD(C_HOLD), .C_HOLD_BITS(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sample_valid(sample_valid),
        .sample(sample),
        .thresh_hi(thresh_hi),
        .thresh_lo(thresh_lo),
`ifdef WARN_LATCH_EN
        .ack(ack),
`endif
        .blink(blink)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: a streak count, a warning flag, and an absolute
    // cycle deadline at which a pending hold expires.
    int  cyc      = 0;
    int  streak   = 0;
    bit  warn     = 0;
    bit  holding  = 0;
    bit  latched  = 0;
    int  deadline = 0;

    function automatic bit m_blink();
        return warn | latched;
    endfunction

    task automatic model_edge();
        bit is_over, is_clear;
        is_over  = (sample >= thresh_hi);
        is_clear = (sample <  thresh_lo);
        if (reset) begin
            streak = 0; warn = 0; holding = 0; latched = 0;
        end else if (latched) begin
            if (sample_valid && is_over) begin
                latched = 0; warn = 1;
            end else if (ack) begin
                latched = 0;
            end
        end else if (warn) begin
            if (holding) begin
                if (sample_valid && !is_clear) begin
                    holding = 0;
                end else if (cyc >= deadline) begin
                    holding = 0;
                    warn    = 0;
`ifdef WARN_LATCH_EN
                    latched = 1;
`endif
                end
            end else if (sample_valid && is_clear) begin
                holding  = 1;
                deadline = cyc + C_HOLD;
            end
        end else if (sample_valid) begin
            if (is_over) streak++;
            else         streak = 0;
            if (streak >= C_ARM) begin
                warn   = 1;
                streak = 0;
            end
        end
    endtask

    // Apply inputs, clock one edge, advance the model, settle for sampling.
    task automatic step(input logic r, input logic v, input logic [C_W-1:0] s, input logic a);
        reset        = r;
        sample_valid = v;
        sample       = s;
        ack          = a;
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
    endtask

    // Negative value means no valid sample this cycle.
    task automatic drive(input int v);
        if (v >= 0) step(1'b0, 1'b1, C_W'(v), 1'b0);
        else        step(1'b0, 1'b0, C_W'($urandom), 1'b0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'($urandom), C_W'($urandom), 1'($urandom));
            tests_run++;
            if (blink !== 1'b0) begin
                fails++;
                $display("FAIL reset[%0d] blink=%b expected 0", i, blink);
            end
        end
    endtask

    task automatic test_arm_streak();
        int s[6]   = '{210, 210, 150, 210, 210, 210};
        bit exp[6] = '{0, 0, 0, 0, 0, 1};
        for (int i = 0; i < 6; i++) begin
            drive(s[i]);
            tests_run++;
            if (blink !== exp[i]) begin
                fails++;
                $display("FAIL arm_streak[%0d] blink=%b expected %b", i, blink, exp[i]);
            end
        end
    endtask

    task automatic test_hold_exit();
        int s[7]   = '{190, 170, -1, -1, -1, -1, -1};
        bit exp[7] = '{1, 1, 1, 1, 1, 0, 0};
        for (int i = 0; i < 7; i++) begin
            drive(s[i]);
            tests_run++;
            if (blink !== exp[i]) begin
                fails++;
                $display("FAIL hold_exit[%0d] blink=%b expected %b", i, blink, exp[i]);
            end
        end
    endtask

    task automatic test_hold_reentry();
        int s[17]   = '{210, 210, 210, 170, -1, 185, -1, -1, -1, -1, -1, 170, -1, -1, -1, -1, -1};
        bit exp[17] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
        for (int i = 0; i < 17; i++) begin
            drive(s[i]);
            tests_run++;
            if (blink !== exp[i]) begin
                fails++;
                $display("FAIL hold_reentry[%0d] blink=%b expected %b", i, blink, exp[i]);
            end
        end
    endtask

    task automatic test_reset_mid_warn();
        int s[3]   = '{210, 210, 210};
        int t[3]   = '{210, 210, 150};
        for (int i = 0; i < 3; i++) drive(s[i]);
        tests_run++;
        if (blink !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_warn_setup blink=%b expected 1", blink);
        end
        step(1'b1, 1'b1, C_W'(210), 1'b0);
        tests_run++;
        if (blink !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_warn_drop blink=%b expected 0", blink);
        end
        for (int i = 0; i < 3; i++) begin
            drive(t[i]);
            tests_run++;
            if (blink !== 1'b0) begin
                fails++;
                $display("FAIL reset_mid_warn_rearm[%0d] blink=%b expected 0", i, blink);
            end
        end
    endtask

    task automatic test_boundary();
        // sample == thresh_hi is over, sample == thresh_lo is not clear.
        int s[13]   = '{200, 200, 200, 180, -1, -1, -1, -1, 179, -1, -1, -1, -1};
        bit exp[13] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
        // Inverted thresholds: 120 is both over and clear.
        bit inv[8]  = '{0, 0, 1, 1, 1, 1, 1, 0};
        for (int i = 0; i < 13; i++) begin
            drive(s[i]);
            tests_run++;
            if (blink !== exp[i]) begin
                fails++;
                $display("FAIL boundary[%0d] blink=%b expected %b", i, blink, exp[i]);
            end
        end
        thresh_hi = 8'd100;
        thresh_lo = 8'd150;
        for (int i = 0; i < 8; i++) begin
            drive(120);
            tests_run++;
            if (blink !== inv[i]) begin
                fails++;
                $display("FAIL inverted_thresh[%0d] blink=%b expected %b", i, blink, inv[i]);
            end
        end
        thresh_hi = 8'd200;
        thresh_lo = 8'd180;
        drive(150);
    endtask

`ifdef WARN_LATCH_EN
    task automatic test_latch();
        int s[7] = '{210, 210, 210, 170, -1, -1, -1};
        for (int i = 0; i < 7; i++) drive(s[i]);
        for (int i = 0; i < 11; i++) begin
            drive(-1);
            tests_run++;
            if (blink !== 1'b1) begin
                fails++;
                $display("FAIL latch_hold[%0d] blink=%b expected 1", i, blink);
            end
        end
        step(1'b0, 1'b0, C_W'(0), 1'b1);
        tests_run++;
        if (blink !== 1'b0) begin
            fails++;
            $display("FAIL latch_ack blink=%b expected 0", blink);
        end
        for (int i = 0; i < 7; i++) drive(s[i]);
        for (int i = 0; i < 3; i++) drive(-1);
        step(1'b0, 1'b1, C_W'(210), 1'b1);
        tests_run++;
        if (blink !== 1'b1) begin
            fails++;
            $display("FAIL latch_rewarn blink=%b expected 1", blink);
        end
        drive(170);
        for (int i = 0; i < 4; i++) drive(-1);
        step(1'b0, 1'b0, C_W'(0), 1'b1);
        tests_run++;
        if (blink !== 1'b0) begin
            fails++;
            $display("FAIL latch_rewarn_ack blink=%b expected 0", blink);
        end
    endtask
`endif

    task automatic test_random();
        logic r, v, a;
        for (int i = 0; i < 3000; i++) begin
            if (i % 150 == 0) begin
                thresh_hi = C_W'($urandom_range(160, 220));
                thresh_lo = C_W'($urandom_range(140, 230));
            end
            r = ($urandom_range(0, 199) == 0);
            v = ($urandom_range(0, 9) < 6);
            a = ($urandom_range(0, 7) == 0);
            step(r, v, C_W'($urandom_range(130, 240)), a);
            tests_run++;
            if (blink !== m_blink()) begin
                fails++;
                $display("FAIL random[%0d] blink=%b expected %b", i, blink, m_blink());
            end
        end
    endtask

    initial begin
        reset        = 1'b1;
        sample_valid = 1'b0;
        sample       = '0;
        ack          = 1'b0;
        thresh_hi    = 8'd200;
        thresh_lo    = 8'd180;

        test_reset();
        test_arm_streak();
        test_hold_exit();
        test_hold_reentry();
        test_reset_mid_warn();
        test_boundary();
`ifdef WARN_LATCH_EN
        test_latch();
`endif
        test_random();

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
